// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_pkg: shared op function codes and muldiv FSM state type
package mips_cpu_pkg;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
  function automatic logic op_valid(input logic [5:0] op);
    return op[5:2] == 4'b0110;
  endfunction
endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if: request, HI/LO move and result bundle of the mul/div unit
interface mips_cpu_muldiv_if;
  logic start;
  logic [5:0] op;
  logic [31:0] a;
  logic [31:0] b;
  logic mthi;
  logic mtlo;
  logic [31:0] wdata;
  logic busy;
  logic done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, mthi, mtlo, wdata, input busy, done, hi, lo);
  modport slave (input start, op, a, b, mthi, mtlo, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_hilo.sv
// mips_cpu_muldiv_hilo: HI/LO registers with move ports and a result write port that wins
module mips_cpu_muldiv_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        mv_hi,
  input  logic        mv_lo,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [31:0] res_hi,
  input  logic [31:0] res_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (mv_hi) hi <= wdata;
      if (mv_lo) lo <= wdata;
    end
  end
endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative MULT/MULTU/DIV/DIVU unit; MIPS_CPU_MULDIV_EARLY_OUT_EN enables multiply early-out
module mips_cpu_muldiv import mips_cpu_pkg::*; (
  input logic clk,
  input logic reset,
  mips_cpu_muldiv_if.slave bus
);
  state_t state, nxt;
  logic mul_r, sgn_r, neg_q, neg_r, early, div0;
  logic [31:0] a_r, b_r, ma, mb, mplier, res_hi, res_lo;
  logic [63:0] acc, mcand, prod;
  logic [32:0] diff;
  logic [4:0] cnt;
  assign ma = sgn_r && a_r[31] ? -a_r : a_r;
  assign mb = sgn_r && b_r[31] ? -b_r : b_r;
  assign div0 = !mul_r && b_r == '0;
  assign diff = acc[63:31] - {1'b0, mcand[31:0]};
  assign prod = neg_q ? -acc : acc;
  assign res_hi = mul_r ? prod[63:32] : neg_r ? -acc[63:32] : acc[63:32];
  assign res_lo = mul_r ? prod[31:0] : neg_q ? -acc[31:0] : acc[31:0];
  assign bus.busy = state != IDLE;
  assign bus.done = state == FIX || (state == PREP && div0);
`ifdef MIPS_CPU_MULDIV_EARLY_OUT_EN
  // multiplicand shifts independently, so stopping early needs no realignment
  assign early = mul_r && mplier[31:1] == '0;
`else
  assign early = 1'b0;
`endif
  always_comb begin
    nxt = state == IDLE ? (bus.start && op_valid(bus.op) ? PREP : IDLE)
        : state == PREP ? (div0 ? IDLE : ITER)
        : state == ITER ? (cnt == 5'd31 || early ? FIX : ITER)
        : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.start) begin
        mul_r <= ~bus.op[1];
        sgn_r <= ~bus.op[0];
        a_r <= bus.a;
        b_r <= bus.b;
      end
      PREP: begin
        acc <= mul_r ? 64'd0 : {32'd0, ma};
        mcand <= {32'd0, mul_r ? ma : mb};
        mplier <= mb;
        neg_q <= sgn_r & (a_r[31] ^ b_r[31]);
        neg_r <= sgn_r & a_r[31];
        cnt <= '0;
      end
      ITER: begin
        cnt <= cnt + 5'd1;
        if (mul_r) begin
          acc <= acc + (mplier[0] ? mcand : 64'd0);
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          acc <= diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
        end
      end
      default: ;
    endcase
  end
  mips_cpu_muldiv_hilo u_hilo (
    .clk(clk),
    .reset(reset),
    .mv_hi(bus.mthi && state == IDLE),
    .mv_lo(bus.mtlo && state == IDLE),
    .wdata(bus.wdata),
    .we(state == FIX),
    .res_hi(res_hi),
    .res_lo(res_lo),
    .hi(bus.hi),
    .lo(bus.lo)
  );
endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk input 1 (rising-edge clock), then reset input 1 (synchronous, active-high).
REQ-002 SHALL have start input 1: request pulse; sampled only in IDLE.
REQ-003 SHALL have op input 6: function code, MULT=011000, MULTU=011001, DIV=011010, DIVU=011011.
REQ-004 SHALL have a input 32 and b input 32: rs/rt operands, sampled with start.
REQ-005 SHALL have mthi input 1, mtlo input 1 and wdata input 32: direct HI/LO write.
REQ-006 SHALL have busy output 1: operation in flight; pipeline stalls MFHI/MFLO/MTHI/MTLO/next op on it.
REQ-007 SHALL have done output 1: single-cycle pulse in the cycle HI/LO take the result.
REQ-008 SHALL have hi output 32 and lo output 32: registered HI/LO contents.

Function
REQ-009 SHALL implement states IDLE, PREP, ITER, FIX; IDLE->PREP on start with a valid op; PREP->ITER; ITER->FIX after 32 iterations; FIX->IDLE.
REQ-010 SHALL ignore start with any op other than the four listed; state stays IDLE, no done.
REQ-011 PREP SHALL latch operand magnitudes (two's-complement negate for MULT/DIV negative operands) and result sign flags.
REQ-012 ITER SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle over a 64-bit accumulator.
REQ-013 FIX SHALL apply sign correction, write HI/LO and assert done: MULT/MULTU {HI,LO}=64-bit product; DIV/DIVU LO=quotient and HI=remainder, with remainder sign equal to the dividend sign and truncation toward zero.
REQ-014 Latency SHALL be start at cycle 0, done at cycle 34, busy=1 in cycles 1..34 and 0 otherwise.
REQ-015 Divide by zero (b==0 for DIV/DIVU) SHALL go PREP->IDLE with done=1 in cycle 1 and HI/LO unchanged.
REQ-016 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wrap, no trap).
REQ-017 mthi/mtlo SHALL write wdata to HI/LO at the next edge only while busy=0; while busy=1 they are ignored.
REQ-018 start together with mthi/mtlo in IDLE: both SHALL be accepted, the move writes at once, and the later FIX write wins.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 hi/lo SHALL remain stable between writes; the intermediate accumulator is never visible.

Reset
REQ-021 reset SHALL force IDLE, busy=0, done=0, hi=0, lo=0 at the next edge, including mid-operation, and the in-flight result SHALL be discarded.
REQ-022 reset SHALL take priority over start, mthi and mtlo.

Configuration
REQ-023 Macro MIPS_CPU_MULDIV_EARLY_OUT_EN, when defined, SHALL make MULT/MULTU leave ITER for FIX as soon as the remaining multiplier register is zero after the current step, with the accumulator pre-aligned so results stay identical.
REQ-024 With the macro defined, minimum multiply latency SHALL be done at cycle 3; divide SHALL be unaffected.
REQ-025 Without the macro, all operations SHALL take the fixed REQ-014 latency.

Structure
REQ-026 The shared package mips_cpu_pkg SHALL hold the op function-code constants and the state enum type.
REQ-027 The HI/LO storage with its move and result write ports SHALL be sub-module mips_cpu_muldiv_hilo; datapath and FSM stay in the top module.

Verification
REQ-028 The bench SHALL cover: MULT a=0xFFFFFFFE b=3 -> done cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 The bench SHALL cover: DIV a=0xFFFFFFF9 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU same operands -> LO=0x7FFFFFFC, HI=1.
REQ-030 The bench SHALL cover: MTHI 0x12345678, then DIVU a=7 b=0 -> done cycle 1, HI=0x12345678, LO unchanged.
REQ-031 The bench SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF with mtlo and a second start during busy -> both ignored, HI=0xFFFFFFFE, LO=1.
REQ-032 The bench SHALL cover: reset at cycle 10 of MULTU -> next cycle busy=0, hi=lo=0, no done.
REQ-033 The bench SHALL cover: with EARLY_OUT_EN, MULTU a=5 b=1 -> done cycle 3, LO=5, HI=0; without it -> done cycle 34.
